sata_cmd_sequencer: RTL and testbench

- Issues one ATA command at a time into the SATA transport layer through its host shadow-register port (HOST_WRITE_EN / HOST_READ_EN / HOST_ADDR_REG / HOST_DATA_IN / HOST_DATA_OUT).
- Waits for the device interrupt (IPF), then reads back the Status/Error register and reports the result to the user.
- Sits between user/AXI control logic and the transport layer, in the same clock domain as the link/transport logic (CLK_OUT).

---
 rtl/sata_seq_pkg.sv | 63 ++++++
 rtl/sata_cmd_sequencer.sv | 169 ++++++++++++++++
 tb/tb_sata_cmd_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sata_seq_pkg.sv
// Shared types and constants for the SATA command sequencer: FSM states,
// shadow-register map, completion codes and the shadow write-word builder.
package sata_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LINK = 3'd1,
    WR_REG    = 3'd2,
    WAIT_DONE = 3'd3,
    RD_STAT   = 3'd4,
    RD_CAP    = 3'd5,
    DONE      = 3'd6
  } seq_state_e;

  localparam logic [4:0] ADDR_FEAT_CNT   = 5'h01;
  localparam logic [4:0] ADDR_LBA_LO     = 5'h02;
  localparam logic [4:0] ADDR_LBA_HI_DEV = 5'h03;
  localparam logic [4:0] ADDR_CMD_STAT   = 5'h07;

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_DEV     = 3'd1;
  localparam logic [2:0] ERR_TIMEOUT = 3'd2;
  localparam logic [2:0] ERR_LINK    = 3'd3;

  localparam int STAT_ERR = 0;
  localparam int STAT_DF  = 5;
  localparam int STAT_BSY = 7;

  // Device byte with the LBA addressing bit set.
  localparam logic [15:0] DEV_LBA_MODE = 16'h0040;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [47:0] lba;
    logic [15:0] count;
    logic [15:0] features;
  } cmd_t;

  function automatic logic [4:0] shadow_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    return ADDR_FEAT_CNT;
      2'd1:    return ADDR_LBA_LO;
      2'd2:    return ADDR_LBA_HI_DEV;
      2'd3:    return ADDR_CMD_STAT;
      default: return ADDR_CMD_STAT;
    endcase
  endfunction

  function automatic logic [31:0] shadow_data(input logic [1:0] idx, input cmd_t c);
    case (idx)
      2'd0:    return {c.features, c.count};
      2'd1:    return c.lba[31:0];
      2'd2:    return {DEV_LBA_MODE, c.lba[47:32]};
      2'd3:    return {24'h00_0000, c.opcode};
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic stat_is_error(input logic [7:0] s);
    return s[STAT_ERR] | s[STAT_DF];
  endfunction

endpackage

// File: rtl/sata_cmd_sequencer.sv
// Issues one ATA command through the transport shadow-register port, waits
// for the device interrupt, reads Status/Error and reports the outcome.
module sata_cmd_sequencer
  import sata_seq_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES   = 32'd150000000,
  parameter logic [23:0] LINK_WAIT_CYCLES = 24'd1000000
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opcode,
  input  logic [47:0] cmd_lba,
  input  logic [15:0] cmd_count,
  input  logic [15:0] cmd_features,
  input  logic        cmd_dma,
  input  logic        linkup,
  input  logic        ipf,
  input  logic        write_hold,
  output logic        host_write_en,
  output logic        host_read_en,
  output logic [4:0]  host_addr,
  output logic [31:0] host_data_out,
  input  logic [31:0] host_data_in,
  output logic        dma_rqst,
  output logic        busy,
  output logic        done,
  output logic [15:0] status,
  output logic [2:0]  err_code
);

  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;
  localparam logic [31:0] LINK_LAST    = {8'h00, LINK_WAIT_CYCLES} - 32'd1;

  seq_state_e  state_r, state_n;
  logic [1:0]  wri_r, wri_n;
  logic [31:0] cnt_r;
  cmd_t        cmd_r, cmd_n;
  logic        we_n, re_n, dma_n, done_n;
  logic [4:0]  addr_n;
  logic [31:0] data_n;
  logic [15:0] status_n;
  logic [2:0]  err_n;
  logic        unused_hi;

  assign unused_hi = ^host_data_in[31:16];
  assign cmd_ready = (state_r == IDLE);
  assign busy      = (state_r != IDLE);

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_n  = state_r;
    wri_n    = wri_r;
    cmd_n    = cmd_r;
    we_n     = 1'b0;
    re_n     = 1'b0;
    addr_n   = host_addr;
    data_n   = host_data_out;
    dma_n    = dma_rqst;
    done_n   = 1'b0;
    status_n = status;
    err_n    = err_code;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          cmd_n    = '{opcode: cmd_opcode, lba: cmd_lba, count: cmd_count, features: cmd_features};
          dma_n    = cmd_dma;
          status_n = 16'h0000;
          err_n    = ERR_OK;
          wri_n    = 2'd0;
          state_n  = linkup ? WR_REG : WAIT_LINK;
        end else begin
          state_n = IDLE;
        end
      end
      WAIT_LINK: begin
        if (linkup) begin
          state_n = WR_REG;
        end else if (cnt_r == LINK_LAST) begin
          state_n = DONE;
          err_n   = ERR_LINK;
          done_n  = 1'b1;
          dma_n   = 1'b0;
        end else begin
          state_n = WAIT_LINK;
        end
      end
      WR_REG: begin
        // Transport back-pressure: hold the index, drop the strobe.
        if (!write_hold) begin
          we_n    = 1'b1;
          addr_n  = shadow_addr(wri_r);
          data_n  = shadow_data(wri_r, cmd_r);
          wri_n   = wri_r + 2'd1;
          state_n = (wri_r == 2'd3) ? WAIT_DONE : WR_REG;
        end else begin
          state_n = WR_REG;
        end
      end
      WAIT_DONE: begin
        if (ipf) begin
          state_n = RD_STAT;
          re_n    = 1'b1;
          addr_n  = ADDR_CMD_STAT;
        end else if (!linkup) begin
          state_n = DONE;
          err_n   = ERR_LINK;
          done_n  = 1'b1;
          dma_n   = 1'b0;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_n = DONE;
          err_n   = ERR_TIMEOUT;
          done_n  = 1'b1;
          dma_n   = 1'b0;
        end else begin
          state_n = WAIT_DONE;
        end
      end
      RD_STAT: state_n = RD_CAP;
      RD_CAP: begin
        status_n = host_data_in[15:0];
        err_n    = stat_is_error(host_data_in[7:0]) ? ERR_DEV : ERR_OK;
        done_n   = 1'b1;
        dma_n    = 1'b0;
        state_n  = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, outputs and the saturating per-state cycle counter.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_r       <= IDLE;
      wri_r         <= 2'd0;
      cnt_r         <= 32'd0;
      cmd_r         <= '0;
      host_write_en <= 1'b0;
      host_read_en  <= 1'b0;
      host_addr     <= 5'h00;
      host_data_out <= 32'h0000_0000;
      dma_rqst      <= 1'b0;
      done          <= 1'b0;
      status        <= 16'h0000;
      err_code      <= ERR_OK;
    end else begin
      state_r       <= state_n;
      wri_r         <= wri_n;
      cmd_r         <= cmd_n;
      host_write_en <= we_n;
      host_read_en  <= re_n;
      host_addr     <= addr_n;
      host_data_out <= data_n;
      dma_rqst      <= dma_n;
      done          <= done_n;
      status        <= status_n;
      err_code      <= err_n;
      if (state_n != state_r)
        cnt_r <= 32'd0;
      else if (cnt_r != 32'hFFFF_FFFF)
        cnt_r <= cnt_r + 32'd1;
      else
        cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_sata_cmd_sequencer.sv
// Scoreboard bench for sata_cmd_sequencer: stimulus pushes expected bus
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_sata_cmd_sequencer;

  logic        clk = 1'b0;
  logic        aresetn, cmd_valid, cmd_ready, cmd_dma, linkup, ipf, write_hold;
  logic [7:0]  cmd_opcode;
  logic [47:0] cmd_lba;
  logic [15:0] cmd_count, cmd_features;
  logic        host_write_en, host_read_en, dma_rqst, busy, done;
  logic [4:0]  host_addr;
  logic [31:0] host_data_out, host_data_in;
  logic [15:0] status;
  logic [2:0]  err_code;
  logic [15:0] rd_val;

  sata_cmd_sequencer #(.TIMEOUT_CYCLES(32'd100), .LINK_WAIT_CYCLES(24'd50)) dut (
    .clk(clk), .aresetn(aresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_lba(cmd_lba), .cmd_count(cmd_count),
    .cmd_features(cmd_features), .cmd_dma(cmd_dma), .linkup(linkup), .ipf(ipf),
    .write_hold(write_hold), .host_write_en(host_write_en), .host_read_en(host_read_en),
    .host_addr(host_addr), .host_data_out(host_data_out), .host_data_in(host_data_in),
    .dma_rqst(dma_rqst), .busy(busy), .done(done), .status(status), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 write, 1 read, 2 done
    logic [4:0]  addr;
    logic [31:0] data;
    logic [2:0]  err;
    logic        dma;
  } exp_t;

  exp_t sb[$];
  int   wr_cyc_q[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, n_wr = 0, n_rd = 0, n_done = 0, n_cmd_wr = 0;
  int   cmd_wr_cyc = 0, done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Transport model: read data appears the cycle after the read strobe.
  always @(posedge clk) host_data_in <= host_read_en ? {16'hFFFF, rd_val} : 32'h0000_0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input int kind, input logic [63:0] act);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_event kind=%0d actual=%0h required=none", kind, act);
    end else begin
      e = sb.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      if (e.kind == 0)      chk("write", act, {26'd0, e.dma, e.addr, e.data});
      else if (e.kind == 1) chk("read_addr", act, {59'd0, e.addr});
      else                  chk("done", act, {45'd0, e.err, e.data[15:0]});
    end
  endtask

  // Monitor: compares every DUT bus event against the scoreboard.
  always @(negedge clk) begin
    if (host_write_en || host_read_en) chk("strobe_exclusive", {63'd0, host_write_en & host_read_en}, 64'd0);
    if (host_write_en) begin
      n_wr++;
      wr_cyc_q.push_back(cyc);
      if (host_addr == 5'h07) begin cmd_wr_cyc = cyc; n_cmd_wr++; end
      pop_cmp(0, {26'd0, dma_rqst, host_addr, host_data_out});
    end
    if (host_read_en) begin n_rd++; pop_cmp(1, {59'd0, host_addr}); end
    if (done) begin n_done++; done_cyc = cyc; pop_cmp(2, {45'd0, err_code, status}); end
  end

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d, input logic dm);
    exp_t e; e.kind = 0; e.addr = a; e.data = d; e.err = 3'd0; e.dma = dm; sb.push_back(e);
  endtask
  task automatic push_rd();
    exp_t e; e.kind = 1; e.addr = 5'h07; e.data = 32'd0; e.err = 3'd0; e.dma = 1'b0; sb.push_back(e);
  endtask
  task automatic push_done(input logic [15:0] s, input logic [2:0] ec);
    exp_t e; e.kind = 2; e.addr = 5'h00; e.data = {16'd0, s}; e.err = ec; e.dma = 1'b0; sb.push_back(e);
  endtask

  task automatic issue(input logic [7:0] op, input logic [47:0] lba, input logic [15:0] cnt,
                       input logic [15:0] feat, input logic dm);
    @(negedge clk);
    chk("cmd_ready_before_issue", {63'd0, cmd_ready}, 64'd1);
    wr_cyc_q.delete();
    cmd_opcode = op; cmd_lba = lba; cmd_count = cnt; cmd_features = feat; cmd_dma = dm;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic pulse_ipf();
    int start; bit seen;
    start = n_cmd_wr; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (n_cmd_wr != start) seen = 1'b1;
    end
    if (!seen) begin checks++; failures++; $display("FAIL cmd_write_timeout actual=none required=write"); end
    ipf = 1'b1;
    @(negedge clk);
    ipf = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int start; bit seen;
    start = n_done; seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (n_done != start) seen = 1'b1;
    end
    if (!seen) begin checks++; failures++; $display("FAIL %s_done_timeout actual=none required=done", name); end
  endtask

  initial begin
    int k, base_rd, base_wr, lk_cyc;
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_dma = 1'b0; linkup = 1'b1; ipf = 1'b0; write_hold = 1'b0;
    cmd_opcode = 8'h00; cmd_lba = 48'd0; cmd_count = 16'd0; cmd_features = 16'd0; rd_val = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {host_write_en, host_read_en, dma_rqst, busy, done, status, err_code, host_addr, host_data_out}, 64'd0);
    chk("reset_ready", {63'd0, cmd_ready}, 64'd1);
    aresetn = 1'b1;

    // READ DMA EXT, nominal completion
    push_wr(5'h01, 32'h0000_0008, 1'b1); push_wr(5'h02, 32'h1234_5678, 1'b1);
    push_wr(5'h03, 32'h0040_0000, 1'b1); push_wr(5'h07, 32'h0000_0025, 1'b1);
    push_rd(); push_done(16'h0050, 3'd0);
    rd_val = 16'h0050;
    issue(8'h25, 48'h0000_1234_5678, 16'd8, 16'd0, 1'b1);
    pulse_ipf();
    wait_done(50, "t1");
    chk("t1_write_count", 64'(wr_cyc_q.size()), 64'd4);
    if (wr_cyc_q.size() == 4) chk("t1_consecutive", 64'(wr_cyc_q[3] - wr_cyc_q[0]), 64'd3);
    @(negedge clk);
    chk("t1_idle_after", {62'd0, busy, dma_rqst}, 64'd0);

    // write_hold during write 1
    push_wr(5'h01, 32'h0001_0010, 1'b1); push_wr(5'h02, 32'h0000_0001, 1'b1);
    push_wr(5'h03, 32'h0040_ABCD, 1'b1); push_wr(5'h07, 32'h0000_0035, 1'b1);
    push_rd(); push_done(16'h0050, 3'd0);
    issue(8'h35, 48'hABCD_0000_0001, 16'h0010, 16'h0001, 1'b1);
    k = 0;
    for (int i = 0; i < 10 && k == 0; i++) begin
      @(negedge clk);
      if (host_write_en) k = 1;
    end
    write_hold = 1'b1;
    repeat (3) @(negedge clk);
    write_hold = 1'b0;
    pulse_ipf();
    wait_done(50, "t2");
    chk("t2_write_count", 64'(wr_cyc_q.size()), 64'd4);
    if (wr_cyc_q.size() == 4) begin
      chk("t2_hold_gap", 64'(wr_cyc_q[1] - wr_cyc_q[0]), 64'd4);
      chk("t2_after_hold", 64'(wr_cyc_q[2] - wr_cyc_q[1]), 64'd1);
    end

    // Timeout: no ipf
    base_rd = n_rd;
    push_wr(5'h01, 32'h0000_0001, 1'b0); push_wr(5'h02, 32'h0000_0010, 1'b0);
    push_wr(5'h03, 32'h0040_0000, 1'b0); push_wr(5'h07, 32'h0000_0020, 1'b0);
    push_done(16'h0000, 3'd2);
    issue(8'h20, 48'h0000_0000_0010, 16'd1, 16'd0, 1'b0);
    wait_done(200, "t3");
    chk("t3_timeout_latency", 64'(done_cyc - cmd_wr_cyc), 64'd100);
    chk("t3_no_read", 64'(n_rd - base_rd), 64'd0);

    // Device error bit in status
    push_wr(5'h01, 32'h0000_0002, 1'b1); push_wr(5'h02, 32'h00AB_CDEF, 1'b1);
    push_wr(5'h03, 32'h0040_0000, 1'b1); push_wr(5'h07, 32'h0000_00C8, 1'b1);
    push_rd(); push_done(16'h0451, 3'd1);
    rd_val = 16'h0451;
    issue(8'hC8, 48'h0000_00AB_CDEF, 16'd2, 16'd0, 1'b1);
    pulse_ipf();
    wait_done(50, "t4");

    // Link comes up after 20 cycles
    linkup = 1'b0;
    push_wr(5'h01, 32'h0000_0000, 1'b0); push_wr(5'h02, 32'h0000_0000, 1'b0);
    push_wr(5'h03, 32'h0040_0000, 1'b0); push_wr(5'h07, 32'h0000_00EC, 1'b0);
    push_rd(); push_done(16'h0050, 3'd0);
    rd_val = 16'h0050;
    issue(8'hEC, 48'd0, 16'd0, 16'd0, 1'b0);
    repeat (20) @(negedge clk);
    linkup = 1'b1;
    lk_cyc = cyc;
    pulse_ipf();
    wait_done(50, "t5");
    if (wr_cyc_q.size() > 0) chk("t5_write_start", 64'(wr_cyc_q[0] - lk_cyc), 64'd2);
    else begin checks++; failures++; $display("FAIL t5_write_start actual=none required=write"); end

    // Link never comes up
    linkup = 1'b0;
    base_wr = n_wr;
    push_done(16'h0000, 3'd3);
    issue(8'h25, 48'h0000_1234_5678, 16'd8, 16'd0, 1'b1);
    wait_done(120, "t6");
    chk("t6_no_writes", 64'(n_wr - base_wr), 64'd0);
    linkup = 1'b1;

    // Reset mid-command after write 1
    push_wr(5'h01, 32'h0000_0008, 1'b1); push_wr(5'h02, 32'h1234_5678, 1'b1);
    issue(8'h25, 48'h0000_1234_5678, 16'd8, 16'd0, 1'b1);
    k = 0;
    for (int i = 0; i < 10 && k < 2; i++) begin
      @(negedge clk);
      if (host_write_en) k++;
    end
    aresetn = 1'b0;
    @(negedge clk);
    chk("t7_reset_outputs", {host_write_en, host_read_en, dma_rqst, busy, done, status, err_code, host_addr, host_data_out}, 64'd0);
    @(negedge clk);
    aresetn = 1'b1;
    repeat (10) @(negedge clk);
    chk("t7_ready_after_reset", {63'd0, cmd_ready}, 64'd1);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
